// File: rtl/regfile_bram_mp_if.sv
// Bus interface for regfile_bram_mp: one broadcast write port, NUM_RD packed read ports, busy flag.
interface regfile_bram_mp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2
);
    logic                         we;
    logic [ADDR_WIDTH-1:0]        wa;
    logic [DATA_WIDTH-1:0]        wd;
    logic [NUM_RD*ADDR_WIDTH-1:0] ra;
    logic [NUM_RD*DATA_WIDTH-1:0] rd;
    logic                         busy;

    modport master (output we, wa, wd, ra, input rd, busy);
    modport slave  (input we, wa, wd, ra, output rd, busy);
endinterface

// File: rtl/regfile_bram_mp.sv
// Multi-read-port register file from replicated SDP BRAM banks with post-reset zero sweep.
// Define REGFILE_FWD_EN to build same-cycle write-to-read forwarding (write-first semantics).
module regfile_bram_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int NUM_RD     = 2,
    parameter bit ZERO_REG   = 1'b1
) (
    input logic              clk,
    input logic              rst,
    regfile_bram_mp_if.slave bus
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] LAST  = CW'(DEPTH - 1);
    localparam logic [CW-1:0] LIMIT = CW'(DEPTH);

    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] READY = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  wa_ok;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) state_d = READY;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The sweep owns the write port while clearing; external writes are dropped, not queued.
    always_comb begin
        wa_ok = {1'b0, bus.wa} < LIMIT;
        if (state_q == CLEAR) begin
            wr_en   = 1'b1;
            wr_addr = cnt_q[ADDR_WIDTH-1:0];
            wr_data = '0;
        end else begin
            wr_en   = bus.we && wa_ok && !(ZERO_REG && (bus.wa == '0));
            wr_addr = bus.wa;
            wr_data = bus.wd;
        end
    end

    assign bus.busy = (state_q == CLEAR);

    for (genvar i = 0; i < NUM_RD; i++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem [DEPTH];
        logic [DATA_WIDTH-1:0] bank_q;
        logic [DATA_WIDTH-1:0] bank_out;
        logic [ADDR_WIDTH-1:0] ra_i;
        logic [ADDR_WIDTH-1:0] rd_addr;
        logic                  ra_ok;
        logic                  live_q;

        assign ra_i    = bus.ra[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign ra_ok   = {1'b0, ra_i} < LIMIT;
        assign rd_addr = ra_ok ? ra_i : '0;

        // Read-first BRAM: a colliding read returns the pre-write contents.
        always_ff @(posedge clk) begin
            if (wr_en) mem[wr_addr] <= wr_data;
            bank_q <= mem[rd_addr];
        end

        // live_q gates out reads sampled during the sweep, of the zero register, or out of range.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                live_q <= 1'b0;
            end else begin
                live_q <= (state_q == READY) && ra_ok && !(ZERO_REG && (ra_i == '0));
            end
        end

`ifdef REGFILE_FWD_EN
        logic                  hit_q;
        logic [DATA_WIDTH-1:0] fwd_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                hit_q <= 1'b0;
                fwd_q <= '0;
            end else begin
                hit_q <= bus.we && (bus.wa == ra_i) && (state_q == READY) &&
                         !(ZERO_REG && (bus.wa == '0));
                fwd_q <= bus.wd;
            end
        end

        assign bank_out = hit_q ? fwd_q : bank_q;
`else
        assign bank_out = bank_q;
`endif

        assign bus.rd[i*DATA_WIDTH +: DATA_WIDTH] = live_q ? bank_out : '0;
    end
endmodule

// File: tb/tb_regfile_bram_mp.sv
// Randomized + directed bench for regfile_bram_mp against an array-based reference model.
module tb_regfile_bram_mp;
    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int NRD   = 4;
    localparam int D2    = 24;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regfile_bram_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NRD)) bus ();
    regfile_bram_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(1))   bus2 ();

    regfile_bram_mp #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_RD(NRD), .ZERO_REG(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    regfile_bram_mp #(.DATA_WIDTH(DW), .DEPTH(D2), .NUM_RD(1), .ZERO_REG(1'b0)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    int ntests = 0;
    int nfail  = 0;

    function automatic void chk(input string name, input logic [DW-1:0] act,
                                input logic [DW-1:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Reference model: plain register array, busy derived from edges since reset release.
    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] exp_rd [NRD];
    logic          exp_busy;
    int            edges;
    bit            ready;
    logic [AW-1:0] a;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            edges    = 0;
            exp_busy = 1'b1;
            for (int k = 0; k < DEPTH; k++) model[k] = '0;
            for (int k = 0; k < NRD; k++) exp_rd[k] = '0;
        end else begin
            ready = (edges >= DEPTH);
            for (int k = 0; k < NRD; k++) begin
                a = bus.ra[k*AW +: AW];
                if (!ready || a == 0) exp_rd[k] = '0;
`ifdef REGFILE_FWD_EN
                else if (bus.we && bus.wa == a) exp_rd[k] = bus.wd;
`endif
                else exp_rd[k] = model[a];
            end
            if (ready && bus.we && bus.wa != 0) model[bus.wa] = bus.wd;
            if (edges < DEPTH) edges++;
            exp_busy = (edges < DEPTH);
        end
    end

    bit check_en = 1'b0;
    always @(negedge clk) begin
        if (check_en) begin
            for (int k = 0; k < NRD; k++)
                chk($sformatf("model_rd%0d", k), bus.rd[k*DW +: DW], exp_rd[k]);
            chk("model_busy", {31'b0, bus.busy}, {31'b0, exp_busy});
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_ra(input int p, input logic [AW-1:0] addr);
        bus.ra[p*AW +: AW] = addr;
    endtask

    task automatic wr(input logic [AW-1:0] addr, input logic [DW-1:0] d);
        bus.we = 1'b1; bus.wa = addr; bus.wd = d;
        tick();
        bus.we = 1'b0;
    endtask

    task automatic wr2(input logic [AW-1:0] addr, input logic [DW-1:0] d);
        bus2.we = 1'b1; bus2.wa = addr; bus2.wd = d;
        tick();
        bus2.we = 1'b0;
    endtask

    // Counts cycles until both instances drop busy; keeps we/wa/wd as currently driven.
    task automatic count_busy(output int n, output int n2);
        n  = 0;
        n2 = -1;
        while ((bus.busy || bus2.busy) && n < 200) begin
            tick();
            n++;
            if (!bus2.busy && n2 < 0) n2 = n;
        end
    endtask

    initial begin
        int n, n2;
        logic [DW-1:0] r;
        bus.we = 0; bus.wa = '0; bus.wd = '0; bus.ra = '0;
        bus2.we = 0; bus2.wa = '0; bus2.wd = '0; bus2.ra = '0;
        #1;
        check_en = 1'b1;
        repeat (3) tick();
        rst = 1'b1;

        // Post-reset sweep length
        count_busy(n, n2);
        chk("sweep_len", DW'(n), 32'd32);
        chk("sweep_len_d24", DW'(n2), 32'd24);

        // Whole file reads zero after the sweep
        for (int b = 0; b < DEPTH; b += NRD) begin
            for (int p = 0; p < NRD; p++) set_ra(p, AW'(b + p));
            tick();
            for (int p = 0; p < NRD; p++)
                chk($sformatf("clear_r%0d", b + p), bus.rd[p*DW +: DW], 32'h0);
        end

        // Basic write/read
        wr(5'd5, 32'hDEADBEEF);
        set_ra(0, 5'd5); set_ra(1, 5'd5);
        tick();
        chk("basic_rd0", bus.rd[0 +: DW], 32'hDEADBEEF);
        chk("basic_rd1", bus.rd[DW +: DW], 32'hDEADBEEF);

        // Zero register, both flavours; out-of-range on the DEPTH=24 instance
        wr(5'd0, 32'h12345678);
        set_ra(0, 5'd0);
        tick();
        chk("zero_reg", bus.rd[0 +: DW], 32'h0);
        wr2(5'd0, 32'h12345678);
        bus2.ra = 5'd0;
        tick();
        chk("zero_plain", bus2.rd, 32'h12345678);
        wr2(5'd30, 32'h5A5A5A5A);
        bus2.ra = 5'd30;
        tick();
        chk("oob_read", bus2.rd, 32'h0);
        wr2(5'd23, 32'hCAFEF00D);
        bus2.ra = 5'd23;
        tick();
        chk("last_addr_d24", bus2.rd, 32'hCAFEF00D);

        // Read/write collision
        wr(5'd7, 32'h11111111);
        bus.we = 1'b1; bus.wa = 5'd7; bus.wd = 32'h22222222;
        set_ra(1, 5'd7);
        tick();
        bus.we = 1'b0;
`ifdef REGFILE_FWD_EN
        r = 32'h22222222;
`else
        r = 32'h11111111;
`endif
        chk("collide", bus.rd[DW +: DW], r);
        tick();
        chk("collide_after", bus.rd[DW +: DW], 32'h22222222);

        // Four independent ports
        wr(5'd1, 32'hA); wr(5'd2, 32'hB); wr(5'd31, 32'hC);
        set_ra(0, 5'd1); set_ra(1, 5'd2); set_ra(2, 5'd1); set_ra(3, 5'd31);
        tick();
        chk("mp_rd0", bus.rd[0*DW +: DW], 32'hA);
        chk("mp_rd1", bus.rd[1*DW +: DW], 32'hB);
        chk("mp_rd2", bus.rd[2*DW +: DW], 32'hA);
        chk("mp_rd3", bus.rd[3*DW +: DW], 32'hC);

        // Random traffic, addresses biased toward a small set to provoke collisions
        for (int c = 0; c < 400; c++) begin
            bus.we = 1'($urandom_range(0, 1));
            bus.wa = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            bus.wd = $urandom;
            for (int p = 0; p < NRD; p++)
                set_ra(p, ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom));
            tick();
        end
        bus.we = 1'b0;

        // Reset in the middle of a sweep, with a write attempted while busy
        wr(5'd3, 32'h33333333);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        repeat (10) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        bus.we = 1'b1; bus.wa = 5'd3; bus.wd = 32'hFFFF0000;
        count_busy(n, n2);
        bus.we = 1'b0;
        chk("resweep_len", DW'(n), 32'd32);
        set_ra(0, 5'd3);
        tick();
        chk("busy_write_lost", bus.rd[0 +: DW], 32'h0);

        tick();
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
